// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle. The master side is the pipeline,
// the slave side is the controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             jump_en_i;
  logic [31:0]      jump_addr_i;
  logic             ld_use_i;
  logic             mdu_start_i;
  logic             mdu_done_i;
  logic             jump_en_o;
  logic [31:0]      jump_addr_o;
  logic             stall_pc_o;
  logic             stall_if_id_o;
  logic             flush_if_id_o;
  logic             stall_id_ex_o;
  logic             flush_id_ex_o;
  logic             mdu_abort_o;
  logic             timeout_err_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output jump_en_i, jump_addr_i, ld_use_i, mdu_start_i, mdu_done_i,
    input  jump_en_o, jump_addr_o, stall_pc_o, stall_if_id_o, flush_if_id_o,
           stall_id_ex_o, flush_id_ex_o, mdu_abort_o, timeout_err_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  jump_en_i, jump_addr_i, ld_use_i, mdu_start_i, mdu_done_i,
    output jump_en_o, jump_addr_o, stall_pc_o, stall_if_id_o, flush_if_id_o,
           stall_id_ex_o, flush_id_ex_o, mdu_abort_o, timeout_err_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: jump flush, load-use bubble, multi-cycle MDU
// stall with timeout abort, plus saturating stall/flush perf counters.
module pipe_hazard_ctrl #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  hz
);

  localparam int TW = $clog2(MDU_TIMEOUT) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(MDU_TIMEOUT - 1);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_LD   = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]       r_state;
  logic [TW-1:0]    r_tcnt;
  logic             r_terr;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [1:0] w_nxt;
  logic       w_jmp, w_sp, w_si, w_fi, w_se, w_fe, w_abort, w_tmo;

  always_comb begin
    w_nxt   = r_state;
    w_jmp   = 1'b0;
    w_sp    = 1'b0;
    w_si    = 1'b0;
    w_fi    = 1'b0;
    w_se    = 1'b0;
    w_fe    = 1'b0;
    w_abort = 1'b0;
    w_tmo   = 1'b0;
    if (hz.jump_en_i) begin
      w_jmp   = 1'b1;
      w_fi    = 1'b1;
      w_fe    = 1'b1;
      w_abort = (r_state == S_WAIT);
      w_nxt   = S_RUN;
    end else begin
      case (r_state)
        S_RUN: begin
          if (hz.mdu_start_i) begin
            w_nxt = S_WAIT;
          end else if (hz.ld_use_i) begin
            w_sp  = 1'b1;
            w_si  = 1'b1;
            w_fe  = 1'b1;
            w_nxt = S_LD;
          end
        end
        S_LD: w_nxt = hz.mdu_start_i ? S_WAIT : S_RUN;
        S_WAIT: begin
          w_sp = 1'b1;
          w_si = 1'b1;
          w_se = 1'b1;
          // done takes precedence over a coinciding timeout
          if (hz.mdu_done_i) begin
            w_nxt = S_RUN;
          end else if (r_tcnt == TO_LAST) begin
            w_abort = 1'b1;
            w_tmo   = 1'b1;
            w_nxt   = S_RUN;
          end
        end
        default: w_nxt = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_RUN;
      r_tcnt      <= '0;
      r_terr      <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_nxt;
      r_tcnt  <= (r_state == S_WAIT && w_nxt == S_WAIT) ? r_tcnt + 1'b1 : '0;
      if (w_tmo)
        r_terr <= 1'b1;
      if (w_sp && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_jmp && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  // combinational outputs are forced low for the whole reset interval
  assign hz.jump_en_o     = rst & w_jmp;
  assign hz.jump_addr_o   = (rst && w_jmp) ? hz.jump_addr_i : 32'h0;
  assign hz.stall_pc_o    = rst & w_sp;
  assign hz.stall_if_id_o = rst & w_si;
  assign hz.flush_if_id_o = rst & w_fi;
  assign hz.stall_id_ex_o = rst & w_se;
  assign hz.flush_id_ex_o = rst & w_fe;
  assign hz.mdu_abort_o   = rst & w_abort;
  assign hz.timeout_err_o = r_terr;
  assign hz.stall_cnt_o   = r_stall_cnt;
  assign hz.flush_cnt_o   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: per-cycle expectations queued at
// drive time, compared on the falling edge.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] NONE   = 7'b000_0000;
  localparam logic [6:0] JMP    = 7'b111_0000;
  localparam logic [6:0] LDB    = 7'b001_1100;
  localparam logic [6:0] STL    = 7'b000_1110;
  localparam logic [6:0] STL_AB = 7'b000_1111;
  localparam logic [6:0] JMP_AB = 7'b111_0001;

  typedef struct packed {
    logic [6:0]  ctl;
    logic [31:0] addr;
    logic        terr;
    logic [3:0]  sc;
    logic [3:0]  fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  logic [3:0] e_sc = '0;
  logic [3:0] e_fc = '0;
  logic       e_terr = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(4)) hz ();
  pipe_hazard_ctrl_if #(.CNT_W(4)) hz2 ();

  pipe_hazard_ctrl #(.MDU_TIMEOUT(8), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .hz(hz.slave)
  );

  // long-timeout twin used for the 20-cycle saturation run
  pipe_hazard_ctrl #(.MDU_TIMEOUT(64), .CNT_W(4)) u_dut_sat (
    .clk(clk), .rst(rst), .hz(hz2.slave)
  );

  assign hz2.jump_en_i   = hz.jump_en_i;
  assign hz2.jump_addr_i = hz.jump_addr_i;
  assign hz2.ld_use_i    = hz.ld_use_i;
  assign hz2.mdu_start_i = hz.mdu_start_i;
  assign hz2.mdu_done_i  = hz.mdu_done_i;

  function automatic logic [6:0] ctl_of();
    return {hz.jump_en_o, hz.flush_if_id_o, hz.flush_id_ex_o, hz.stall_pc_o,
            hz.stall_if_id_o, hz.stall_id_ex_o, hz.mdu_abort_o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ctl"},  32'(ctl_of()), 32'h0);
    chk({tag, ".addr"}, hz.jump_addr_o, 32'h0);
    chk({tag, ".terr"}, 32'(hz.timeout_err_o), 32'h0);
    chk({tag, ".sc"},   32'(hz.stall_cnt_o), 32'h0);
    chk({tag, ".fc"},   32'(hz.flush_cnt_o), 32'h0);
  endtask

  task automatic drive(input logic j, input logic [31:0] a, input logic ld,
                       input logic st, input logic dn);
    hz.jump_en_i   = j;
    hz.jump_addr_i = a;
    hz.ld_use_i    = ld;
    hz.mdu_start_i = st;
    hz.mdu_done_i  = dn;
  endtask

  task automatic step(input logic j, input logic [31:0] a, input logic ld,
                      input logic st, input logic dn, input logic [6:0] ctl);
    exp_t e;
    @(posedge clk); #1;
    drive(j, a, ld, st, dn);
    e.ctl  = ctl;
    e.addr = j ? a : 32'h0;
    e.terr = e_terr;
    e.sc   = e_sc;
    e.fc   = e_fc;
    sb_q.push_back(e);
    if (ctl[3] && e_sc != 4'hF) e_sc = e_sc + 4'd1;
    if (j && e_fc != 4'hF)      e_fc = e_fc + 4'd1;
  endtask

  task automatic idle(input int n, input logic [6:0] ctl);
    for (int i = 0; i < n; i++) step(0, 32'h0, 0, 0, 0, ctl);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    drive(0, 32'h0, 0, 0, 0);
    e_sc = '0; e_fc = '0; e_terr = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin : sb_chk
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("ctl",  32'(ctl_of()), 32'(e.ctl));
      chk("addr", hz.jump_addr_o, e.addr);
      chk("terr", 32'(hz.timeout_err_o), 32'(e.terr));
      chk("sc",   32'(hz.stall_cnt_o), 32'(e.sc));
      chk("fc",   32'(hz.flush_cnt_o), 32'(e.fc));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with aggressive inputs: everything combinational must be low
    drive(1, 32'hFFFF_FFF0, 1, 1, 1);
    #3 chk_zero("rst");
    @(posedge clk); #2;
    drive(0, 32'h0, 0, 0, 0);
    rst = 1'b1;

    // load-use held two cycles: single bubble
    step(0, 32'h0, 1, 0, 0, LDB);
    step(0, 32'h0, 1, 0, 0, NONE);
    step(0, 32'h0, 0, 0, 0, NONE);

    // jump flush
    step(1, 32'h0000_0100, 0, 0, 0, JMP);
    step(0, 32'h0, 0, 0, 0, NONE);

    // MDU with done five cycles after start
    step(0, 32'h0, 0, 1, 0, NONE);
    idle(4, STL);
    step(0, 32'h0, 0, 0, 1, STL);
    step(0, 32'h0, 0, 0, 1, NONE);
    step(0, 32'h0, 0, 0, 0, NONE);

    // all events at once in RUN: jump only, stays in RUN
    step(1, 32'hDEAD_BEE0, 1, 1, 0, JMP);
    step(0, 32'h0, 0, 0, 0, NONE);

    // start from LD_BUBBLE, then jump inside WAIT_MDU aborts
    step(0, 32'h0, 1, 0, 0, LDB);
    step(0, 32'h0, 0, 1, 0, NONE);
    step(0, 32'h0, 0, 0, 0, STL);
    step(1, 32'h0000_2000, 0, 0, 0, JMP_AB);
    step(0, 32'h0, 0, 0, 0, NONE);

    // timeout on the short DUT; the long twin keeps stalling for 20 cycles
    do_reset();
    step(0, 32'h0, 0, 1, 0, NONE);
    idle(7, STL);
    step(0, 32'h0, 0, 0, 0, STL_AB);
    e_terr = 1'b1;
    idle(11, NONE);
    step(0, 32'h0, 0, 0, 1, NONE);
    step(0, 32'h0, 0, 0, 0, NONE);
    chk("sat.sc", 32'(hz2.stall_cnt_o), 32'hF);
    step(0, 32'h0, 0, 0, 0, NONE);

    // reset asserted in the middle of WAIT_MDU
    step(0, 32'h0, 0, 1, 0, NONE);
    idle(2, STL);
    @(posedge clk); #1;
    drive(1, 32'h0000_0055, 1, 0, 0);
    #1 rst = 1'b0;
    #1 chk_zero("midrst");
    chk("midrst.sat_ctl", 32'(hz2.stall_pc_o | hz2.mdu_abort_o), 32'h0);
    @(posedge clk); #2;
    drive(0, 32'h0, 0, 0, 0);
    rst = 1'b1;
    e_sc = '0; e_fc = '0; e_terr = 1'b0;
    step(0, 32'h0, 0, 0, 0, NONE);
    step(0, 32'h0, 1, 0, 0, LDB);
    step(0, 32'h0, 0, 0, 0, NONE);

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
